// File: rtl/sub_pe_pkg.sv
// Shared defaults and FSM encoding for the sub_pe operand feeder.
package sub_pe_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_CH_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/feeder_addr_gen.sv
// Per-buffer address generator: latches a base and pair count, then walks
// base+idx (modulo 2^ADDR_W) one step per fetch cycle.
module feeder_addr_gen
  import sub_pe_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CH_W-1:0]   i_count,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [CH_W-1:0]   r_count;
  logic [CH_W-1:0]   r_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base  <= '0;
      r_count <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_base  <= i_base;
      r_count <= i_count;
      r_idx   <= '0;
    end else if (i_step) begin
      r_idx <= r_idx + CH_W'(1);
    end
  end

  // Carry out of the adder is dropped, giving the modulo wrap.
  assign o_addr = r_base + ADDR_W'(r_idx);
  assign o_last = (r_idx == r_count);

endmodule

// File: rtl/sub_pe_feeder.sv
// Operand sequencer for one sub_pe: fetches channel+1 img/weight pairs from
// two 1-cycle-latency buffers and streams them with start/done framing.
module sub_pe_feeder
  import sub_pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_img_base,
  input  logic [ADDR_W-1:0] cmd_wgt_base,
  input  logic [CH_W-1:0]   cmd_channel,
  output logic              img_rd_en,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_rdata,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_addr,
  input  logic [DATA_W-1:0] wgt_rdata,
  output logic              start,
  output logic [DATA_W-1:0] img,
  output logic [DATA_W-1:0] weight,
  output logic [CH_W-1:0]   channel,
  output logic              op_valid,
  output logic              done
);

  state_t            r_state;
  logic [CH_W-1:0]   r_channel;
  logic              r_v1;
  logic              r_first1;
  logic              r_op_valid;
  logic              r_start;
  logic [DATA_W-1:0] r_img;
  logic [DATA_W-1:0] r_wgt;

  logic              w_accept;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_img_addr;
  logic [ADDR_W-1:0] w_wgt_addr;
  logic              w_img_last;
  logic              w_wgt_last;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_fetch  = (r_state == ST_FETCH);

  feeder_addr_gen #(.ADDR_W(ADDR_W), .CH_W(CH_W)) u_img_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_step  (w_fetch),
    .i_base  (cmd_img_base),
    .i_count (cmd_channel),
    .o_addr  (w_img_addr),
    .o_last  (w_img_last)
  );

  feeder_addr_gen #(.ADDR_W(ADDR_W), .CH_W(CH_W)) u_wgt_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_step  (w_fetch),
    .i_base  (cmd_wgt_base),
    .i_count (cmd_channel),
    .o_addr  (w_wgt_addr),
    .o_last  (w_wgt_last)
  );

  // NOTE: reset is synchronous and clears every register, including the data
  // pipeline, so a mid-stream abort leaves nothing live on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_channel  <= '0;
      r_v1       <= 1'b0;
      r_first1   <= 1'b0;
      r_op_valid <= 1'b0;
      r_start    <= 1'b0;
      r_img      <= '0;
      r_wgt      <= '0;
    end else begin
      // Stage 1 mirrors the buffer latency; FETCH is always entered from
      // IDLE, so its first cycle is the one with no fetch behind it.
      r_v1       <= w_fetch;
      r_first1   <= w_fetch && !r_v1;
      r_op_valid <= r_v1;
      r_start    <= r_first1;
      r_img      <= r_v1 ? img_rdata : '0;
      r_wgt      <= r_v1 ? wgt_rdata : '0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_FETCH;
            r_channel <= cmd_channel;
          end
        end
        ST_FETCH: begin
          if (w_img_last && w_wgt_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_op_valid && !r_v1) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign img_rd_en = w_fetch;
  assign wgt_rd_en = w_fetch;
  assign img_addr  = w_fetch ? w_img_addr : '0;
  assign wgt_addr  = w_fetch ? w_wgt_addr : '0;
  assign start     = r_start;
  assign op_valid  = r_op_valid;
  assign img       = r_img;
  assign weight    = r_wgt;
  assign channel   = r_channel;

endmodule

// File: tb/tb_sub_pe_feeder.sv
// Directed bench for sub_pe_feeder with behavioural 1-cycle-latency buffers.
module tb_sub_pe_feeder;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_img_base;
  logic [AW-1:0] cmd_wgt_base;
  logic [CW-1:0] cmd_channel;
  logic          img_rd_en;
  logic [AW-1:0] img_addr;
  logic [DW-1:0] img_rdata;
  logic          wgt_rd_en;
  logic [AW-1:0] wgt_addr;
  logic [DW-1:0] wgt_rdata;
  logic          start;
  logic [DW-1:0] img;
  logic [DW-1:0] weight;
  logic [CW-1:0] channel;
  logic          op_valid;
  logic          done;

  always #5 clk = ~clk;

  sub_pe_feeder #(.DATA_W(DW), .ADDR_W(AW), .CH_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_img_base (cmd_img_base),
    .cmd_wgt_base (cmd_wgt_base),
    .cmd_channel  (cmd_channel),
    .img_rd_en    (img_rd_en),
    .img_addr     (img_addr),
    .img_rdata    (img_rdata),
    .wgt_rd_en    (wgt_rd_en),
    .wgt_addr     (wgt_addr),
    .wgt_rdata    (wgt_rdata),
    .start        (start),
    .img          (img),
    .weight       (weight),
    .channel      (channel),
    .op_valid     (op_valid),
    .done         (done)
  );

  // Buffers: img[a] = a+3, wgt[a] = a+1 (mod 256).
  logic [DW-1:0] img_mem [0:1023];
  logic [DW-1:0] wgt_mem [0:1023];

  always @(posedge clk) begin
    if (img_rd_en) img_rdata <= img_mem[img_addr];
    if (wgt_rd_en) wgt_rdata <= wgt_mem[wgt_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [CW-1:0] ch;
    logic [AW-1:0] ib;
    logic [AW-1:0] wb;
    logic [DW-1:0] img0;
    logic [DW-1:0] wgt0;
  } vec_t;

  vec_t vecs [4];

  task automatic issue(input logic [CW-1:0] ch, input logic [AW-1:0] ib, input logic [AW-1:0] wb);
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_channel  = ch;
    cmd_img_base = ib;
    cmd_wgt_base = wb;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Issues one command and checks every output in cycles T+1..T+N+4.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int starts;
    int dones;
    logic [DW-1:0] ei;
    logic [DW-1:0] ew;
    logic [AW-1:0] ea;
    logic [AW-1:0] eb;
    n      = int'(v.ch) + 1;
    starts = 0;
    dones  = 0;
    issue(v.ch, v.ib, v.wb);
    for (int j = 1; j <= n + 4; j++) begin
      if (j > 1) @(negedge clk);
      check($sformatf("%s cmd_ready@%0d", tag, j), 32'(cmd_ready), 32'(j >= n + 4));
      check($sformatf("%s img_rd_en@%0d", tag, j), 32'(img_rd_en), 32'(j <= n));
      check($sformatf("%s wgt_rd_en@%0d", tag, j), 32'(wgt_rd_en), 32'(j <= n));
      if (j <= n) begin
        ea = v.ib + AW'(j - 1);
        eb = v.wb + AW'(j - 1);
        check($sformatf("%s img_addr@%0d", tag, j), 32'(img_addr), 32'(ea));
        check($sformatf("%s wgt_addr@%0d", tag, j), 32'(wgt_addr), 32'(eb));
      end
      check($sformatf("%s op_valid@%0d", tag, j), 32'(op_valid), 32'(j >= 3 && j <= n + 2));
      check($sformatf("%s start@%0d", tag, j), 32'(start), 32'(j == 3));
      check($sformatf("%s done@%0d", tag, j), 32'(done), 32'(j == n + 3));
      check($sformatf("%s channel@%0d", tag, j), 32'(channel), 32'(v.ch));
      if (j >= 3 && j <= n + 2) begin
        ei = v.img0 + DW'(j - 3);
        ew = v.wgt0 + DW'(j - 3);
      end else begin
        ei = '0;
        ew = '0;
      end
      check($sformatf("%s img@%0d", tag, j), 32'(img), 32'(ei));
      check($sformatf("%s weight@%0d", tag, j), 32'(weight), 32'(ew));
      starts += int'(start);
      dones  += int'(done);
    end
    check($sformatf("%s start_count", tag), 32'(starts), 32'd1);
    check($sformatf("%s done_count", tag), 32'(dones), 32'd1);
  endtask

  // Second command held from T+1 must wait until cmd_ready returns at T+8.
  task automatic back_to_back();
    int s1;
    int s2;
    int starts;
    int dones;
    s1 = -1;
    s2 = -1;
    starts = 0;
    dones  = 0;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_channel  = 3'd3;
    cmd_img_base = 10'h000;
    cmd_wgt_base = 10'h100;
    @(negedge clk);
    cmd_channel  = 3'd5;
    cmd_img_base = 10'h040;
    cmd_wgt_base = 10'h140;
    for (int j = 1; j <= 22; j++) begin
      if (j > 1) @(negedge clk);
      if (j <= 7) check($sformatf("b2b busy cmd_ready@%0d", j), 32'(cmd_ready), 32'd0);
      if (j == 8) begin
        check("b2b cmd_ready@8", 32'(cmd_ready), 32'd1);
        check("b2b channel_old@8", 32'(channel), 32'd3);
      end
      if (j == 9) begin
        cmd_valid = 1'b0;
        check("b2b cmd_ready@9", 32'(cmd_ready), 32'd0);
        check("b2b channel_new@9", 32'(channel), 32'd5);
      end
      if (j == 11) begin
        check("b2b img0_B", 32'(img), 32'h43);
        check("b2b wgt0_B", 32'(weight), 32'h41);
      end
      if (start) begin
        if (s1 < 0) s1 = j;
        else s2 = j;
        starts++;
      end
      dones += int'(done);
    end
    check("b2b first_start", 32'(s1), 32'd3);
    check("b2b second_start", 32'(s2), 32'd11);
    check("b2b start_count", 32'(starts), 32'd2);
    check("b2b done_count", 32'(dones), 32'd2);
  endtask

  task automatic reset_mid_stream();
    logic [DW-1:0] ei;
    issue(3'd7, 10'h020, 10'h120);
    for (int j = 1; j <= 5; j++) begin
      if (j > 1) @(negedge clk);
      if (j >= 3) begin
        ei = 8'h23 + DW'(j - 3);
        check($sformatf("rst pre op_valid@%0d", j), 32'(op_valid), 32'd1);
        check($sformatf("rst pre img@%0d", j), 32'(img), 32'(ei));
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst rd_en", 32'({img_rd_en, wgt_rd_en}), 32'd0);
    check("rst addr", 32'({img_addr, wgt_addr}), 32'd0);
    check("rst framing", 32'({start, op_valid, done}), 32'd0);
    check("rst data", 32'({img, weight}), 32'd0);
    check("rst channel", 32'(channel), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("rst quiet done@%0d", k), 32'(done), 32'd0);
      check($sformatf("rst quiet rd_en@%0d", k), 32'({img_rd_en, wgt_rd_en}), 32'd0);
      check($sformatf("rst quiet op_valid@%0d", k), 32'(op_valid), 32'd0);
    end
    run_vec(vecs[0], "after_rst");
  endtask

  initial begin
    vecs[0] = '{ch: 3'd3, ib: 10'h000, wb: 10'h100, img0: 8'h03, wgt0: 8'h01};
    vecs[1] = '{ch: 3'd0, ib: 10'h010, wb: 10'h200, img0: 8'h13, wgt0: 8'h01};
    vecs[2] = '{ch: 3'd3, ib: 10'h3FE, wb: 10'h050, img0: 8'h01, wgt0: 8'h51};
    vecs[3] = '{ch: 3'd7, ib: 10'h0F8, wb: 10'h3FC, img0: 8'hFB, wgt0: 8'hFD};

    for (int a = 0; a < 1024; a++) begin
      img_mem[a] = DW'(a + 3);
      wgt_mem[a] = DW'(a + 1);
    end
    img_rdata    = '0;
    wgt_rdata    = '0;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_img_base = '0;
    cmd_wgt_base = '0;
    cmd_channel  = '0;
    repeat (3) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset rd_en", 32'({img_rd_en, wgt_rd_en}), 32'd0);
    check("reset framing", 32'({start, op_valid, done}), 32'd0);
    check("reset data", 32'({img, weight}), 32'd0);
    check("reset channel", 32'(channel), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) run_vec(vecs[v], $sformatf("vec%0d", v));
    back_to_back();
    reset_mid_stream();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
